// File: rtl/key_pkg.sv
// Shared types and elaboration-time helpers for the multi-key debouncer.
package key_pkg;

  // Per-channel hold tracking: released, held before the long-press point, and long-held.
  typedef enum logic [1:0] {
    REL  = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } key_state_t;

  // Converts a duration in milliseconds into clock cycles.
  function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
    return (freq / 1000) * ms;
  endfunction

  // Counter width able to hold 0 .. n-1. This is never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: 2-flop synchroniser, debounce counter and REL/HELD/LONG hold FSM.
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned DEB_CNT    = 4,
  parameter int unsigned LONG_CNT   = 20,
  parameter int unsigned REP_CNT    = 0,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int unsigned DEB_W    = cnt_width(DEB_CNT);
  localparam int unsigned HOLD_MAX = (LONG_CNT > REP_CNT) ? LONG_CNT : REP_CNT;
  localparam int unsigned HOLD_W   = cnt_width(HOLD_MAX);
  localparam bit          REP_EN   = (REP_CNT > 0);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CNT - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CNT - 1);
  // Unused when REP_CNT is 0, since repeat is then disabled.
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'((REP_CNT > 0) ? REP_CNT - 1 : 0);

  logic              sync1, sync2;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  key_state_t        state_q, state_d;
  logic              level_q, level_d;
  logic              press_d, release_d, long_d, repeat_d;
  logic              press_q, release_q, long_q, repeat_q;
  logic              differ, accept;

  // Synchronise the polarity-corrected pin into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= key_raw ^ ACTIVE_LOW;
      sync2 <= sync1;
    end
  end

  // Debounce: the count runs only while the synced input disagrees with the level.
  always_comb begin
    differ    = sync2 ^ level_q;
    accept    = differ && (deb_cnt_q == DEB_LAST);
    deb_cnt_d = '0;
    level_d   = level_q;
    if (differ && !accept) begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
    if (accept) begin
      level_d = ~level_q;
    end
    press_d   = accept & ~level_q;
    release_d = accept & level_q;
  end

  // Hold FSM next-state logic. A release accepted in this cycle takes priority over long and repeat.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    unique case (state_q)
      REL: begin
        if (press_d) begin
          state_d    = HELD;
          hold_cnt_d = '0;
        end
      end
      HELD: begin
        if (release_d) begin
          state_d    = REL;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == LONG_LAST) begin
          long_d     = 1'b1;
          state_d    = LONG;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      LONG: begin
        if (release_d) begin
          state_d    = REL;
          hold_cnt_d = '0;
        end else if (REP_EN) begin
          if (hold_cnt_q == REP_LAST) begin
            repeat_d   = 1'b1;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = REL;
        hold_cnt_d = '0;
      end
    endcase
  end

  // State, counters and registered one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      state_q    <= REL;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      state_q    <= state_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  assign key_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/multi_key_debounce.sv
// N independent key conditioners. The top derives cycle counts and concatenates the channel outputs.
module multi_key_debounce
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS      = 4,
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 0,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);

  localparam int unsigned DEB_CNT  = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int unsigned LONG_CNT = ms_to_cycles(CLK_FREQ_HZ, LONG_MS);
  localparam int unsigned REP_CNT  = ms_to_cycles(CLK_FREQ_HZ, REPEAT_MS);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .DEB_CNT   (DEB_CNT),
      .LONG_CNT  (LONG_CNT),
      .REP_CNT   (REP_CNT),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .key_raw      (key_in[i]),
      .key_level    (key_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_multi_key_debounce.sv
// Directed bench: DEB_CNT=4, LONG_CNT=20, REP_CNT=5, with an active-high and an active-low copy.
module tb_multi_key_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] key_in_n;
  logic [3:0] lvl, pp, rp, lp, rpp;
  logic [3:0] lvl_n, pp_n, rp_n, lp_n, rpp_n;
  int checks = 0;
  int errors = 0;

  assign key_in_n = ~key_in;

  always #5 clk = ~clk;

  multi_key_debounce #(
    .N_KEYS(4), .CLK_FREQ_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .REPEAT_MS(5), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_level(lvl), .press_pulse(pp),
    .release_pulse(rp), .long_pulse(lp), .repeat_pulse(rpp)
  );

  multi_key_debounce #(
    .N_KEYS(4), .CLK_FREQ_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .REPEAT_MS(5), .ACTIVE_LOW(1'b1)
  ) dut_n (
    .clk(clk), .rst(rst), .key_in(key_in_n), .key_level(lvl_n), .press_pulse(pp_n),
    .release_pulse(rp_n), .long_pulse(lp_n), .repeat_pulse(rpp_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_in = 4'h0;
    tick();
    tick();
    checks++;
    if ({lvl, pp, rp, lp, rpp} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", {lvl, pp, rp, lp, rpp}, 20'h0);
    end
    checks++;
    if ({lvl_n, pp_n, rp_n, lp_n, rpp_n} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs_n got %h want %h", {lvl_n, pp_n, rp_n, lp_n, rpp_n}, 20'h0);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_clean_press();
    key_in[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (pp !== 4'h0 || lvl !== 4'h0) begin
        errors++;
        $display("FAIL clean_early edge %0d got pp=%b lvl=%b want 0000", i, pp, lvl);
      end
    end
    tick();
    checks++;
    if (pp !== 4'b0001 || lvl !== 4'b0001) begin
      errors++;
      $display("FAIL clean_edge6 got pp=%b lvl=%b want 0001", pp, lvl);
    end
    tick();
    checks++;
    if (pp !== 4'b0000 || lvl !== 4'b0001) begin
      errors++;
      $display("FAIL clean_edge7 got pp=%b lvl=%b want pp=0000 lvl=0001", pp, lvl);
    end
    key_in[0] = 1'b0;
    repeat (6) tick();
    checks++;
    if (rp !== 4'b0001 || lvl !== 4'b0000) begin
      errors++;
      $display("FAIL clean_release got rp=%b lvl=%b want rp=0001 lvl=0000", rp, lvl);
    end
    tick();
    checks++;
    if (rp !== 4'b0000) begin
      errors++;
      $display("FAIL clean_release_len got rp=%b want 0000", rp);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] seen;
    seen = 4'h0;
    key_in[1] = 1'b1; tick(); seen |= pp | rp;
    key_in[1] = 1'b0; tick(); seen |= pp | rp;
    key_in[1] = 1'b1; tick(); seen |= pp | rp;
    key_in[1] = 1'b0; tick(); seen |= pp | rp;
    key_in[1] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      seen |= pp | rp;
    end
    checks++;
    if (seen !== 4'h0) begin
      errors++;
      $display("FAIL bounce_quiet got pulses=%b want 0000", seen);
    end
    tick();
    checks++;
    if (pp !== 4'b0010 || lvl !== 4'b0010) begin
      errors++;
      $display("FAIL bounce_press got pp=%b lvl=%b want 0010", pp, lvl);
    end
    seen = 4'h0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      seen |= pp | rp;
    end
    checks++;
    if (seen !== 4'h0) begin
      errors++;
      $display("FAIL bounce_single got extra pulses=%b want 0000", seen);
    end
    key_in[1] = 1'b0;
    repeat (6) tick();
    checks++;
    if (rp !== 4'b0010 || lvl !== 4'b0000) begin
      errors++;
      $display("FAIL bounce_release got rp=%b lvl=%b want rp=0010 lvl=0000", rp, lvl);
    end
  endtask

  // The release lands on +45, the same cycle the fifth repeat would fire, so the repeat must be suppressed.
  task automatic test_long_repeat();
    logic [3:0] got, exp;
    key_in[2] = 1'b1;
    repeat (6) tick();
    checks++;
    if (pp !== 4'b0100) begin
      errors++;
      $display("FAIL long_press got pp=%b want 0100", pp);
    end
    for (int i = 1; i <= 60; i++) begin
      if (i == 40) key_in[2] = 1'b0;
      tick();
      got = {lp[2], rpp[2], rp[2], lvl[2]};
      exp = {i == 20, (i == 25 || i == 30 || i == 35 || i == 40), i == 45, i < 45};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL long_repeat +%0d got {long,rep,rel,lvl}=%b want %b", i, got, exp);
      end
    end
  endtask

  task automatic test_short_press();
    logic [2:0] got, exp;
    key_in[3] = 1'b1;
    repeat (6) tick();
    checks++;
    if (pp !== 4'b1000) begin
      errors++;
      $display("FAIL short_press got pp=%b want 1000", pp);
    end
    for (int i = 1; i <= 30; i++) begin
      if (i == 5) key_in[3] = 1'b0;
      tick();
      got = {lp[3], rp[3], lvl[3]};
      exp = {1'b0, i == 10, i < 10};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL short +%0d got {long,rel,lvl}=%b want %b", i, got, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    key_in = 4'hf;
    repeat (5) tick();
    checks++;
    if (pp !== 4'h0 || pp_n !== 4'h0) begin
      errors++;
      $display("FAIL simul_early got pp=%b pp_n=%b want 0000", pp, pp_n);
    end
    tick();
    checks++;
    if (pp !== 4'hf || lvl !== 4'hf) begin
      errors++;
      $display("FAIL simul_press got pp=%b lvl=%b want 1111", pp, lvl);
    end
    checks++;
    if (pp_n !== 4'hf || lvl_n !== 4'hf) begin
      errors++;
      $display("FAIL simul_press_n got pp=%b lvl=%b want 1111", pp_n, lvl_n);
    end
    tick();
    checks++;
    if (pp !== 4'h0 || pp_n !== 4'h0) begin
      errors++;
      $display("FAIL simul_pulse_len got pp=%b pp_n=%b want 0000", pp, pp_n);
    end
    key_in = 4'h0;
    repeat (6) tick();
    checks++;
    if (rp !== 4'hf || rp_n !== 4'hf || lvl !== 4'h0 || lvl_n !== 4'h0) begin
      errors++;
      $display("FAIL simul_release got rp=%b rp_n=%b lvl=%b lvl_n=%b want rp=1111 lvl=0000",
               rp, rp_n, lvl, lvl_n);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] got, exp;
    key_in[0] = 1'b1;
    repeat (6) tick();
    checks++;
    if (pp !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_press got pp=%b want 0001", pp);
    end
    repeat (20) tick();
    checks++;
    if (lp !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_long got lp=%b want 0001", lp);
    end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({lvl, pp, rp, lp, rpp} !== 20'h0) begin
      errors++;
      $display("FAIL rstmid_clear got %h want %h", {lvl, pp, rp, lp, rpp}, 20'h0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      got = {pp[0], rp[0], lvl[0]};
      exp = {i == 6, 1'b0, i >= 6};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rstmid +%0d got {press,rel,lvl}=%b want %b", i, got, exp);
      end
    end
    key_in = 4'h0;
  endtask

  initial begin
    rst = 1'b1;
    key_in = 4'h0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_short_press();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_key_debounce.md
Name: multi_key_debounce

Overview:
Parametrised N-channel push-button conditioner: the next-generation debouncer for board keys. Each channel does the following:
- synchronises its raw input;
- debounces it with a configurable time;
- outputs a stable level plus one-cycle press and release pulses;
- outputs a one-shot long-press pulse and, optionally, auto-repeat pulses.

It sits between board pins and any FSM that consumes key events, such as counters or mode selectors.

Parameters:
N_KEYS, 4, number of independent key channels
CLK_FREQ_HZ, 100_000_000, clk frequency; derived counts use it
DEBOUNCE_MS, 20, stable time required to accept a level change; DEB_CNT = CLK_FREQ_HZ/1000*DEBOUNCE_MS, must be ≥ 2
LONG_MS, 1000, hold time before long_pulse; LONG_CNT = CLK_FREQ_HZ/1000*LONG_MS, must be > DEB_CNT
REPEAT_MS, 0, auto-repeat period after long press; 0 disables repeat; REP_CNT derived the same way
ACTIVE_LOW, 0, 1 means raw pin reads 0 when pressed (inverted at the input)

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous, active-high reset
key_in  input  N_KEYS  raw asynchronous key pins
key_level  output  N_KEYS  debounced level, 1 = pressed
press_pulse  output  N_KEYS  1-cycle pulse on accepted press
release_pulse  output  N_KEYS  1-cycle pulse on accepted release
long_pulse  output  N_KEYS  1-cycle pulse when hold reaches LONG_CNT
repeat_pulse  output  N_KEYS  1-cycle pulse every REP_CNT cycles after long_pulse while still held

Behaviour:
Input conditioning:
- Per channel, the raw bit is XORed with ACTIVE_LOW, giving logical 1 = pressed.
- This feeds a 2-flop synchroniser (sync1, sync2).

Reset (rst high at a clk edge):
- sync flops are set to 0.
- All counters are set to 0.
- All outputs are set to 0.
- FSM goes to REL.
- Consequence: a key already held through reset produces press_pulse only after a full debounce.

Debounce counter:
- deb_cnt increments each cycle that sync2 != key_level.
- deb_cnt clears to 0 in any cycle that sync2 == key_level; any glitch restarts the count.
- When sync2 != key_level and deb_cnt == DEB_CNT-1, the next edge does all of the following:
  - toggles key_level;
  - clears deb_cnt;
  - asserts press_pulse or release_pulse for exactly that cycle.

Latency:
- Counting the first edge that samples a new key_in as edge 1, key_level and the pulse update at edge DEB_CNT+2.

Per-channel FSM, states {REL, HELD, LONG}:
- REL: enters HELD on accepted press and clears hold_cnt.
- HELD: hold_cnt increments each cycle.
  - When hold_cnt reaches LONG_CNT-1: long_pulse for 1 cycle, go to LONG, clear hold_cnt.
  - Accepted release: go to REL, no long_pulse.
- LONG: if REPEAT_MS > 0, hold_cnt counts to REP_CNT-1, then repeat_pulse for 1 cycle and hold_cnt wraps to 0. This repeats indefinitely.
  - If REPEAT_MS == 0: no repeat, hold_cnt frozen.
  - Accepted release: go to REL, hold_cnt cleared.
- long_pulse fires at most once per press.
- A release accepted in the same cycle that hold_cnt would fire suppresses long_pulse or repeat_pulse; release_pulse wins.

Widths and independence:
- Counter widths are $clog2 of the largest count; no overflow is possible because every counter wraps or clears before its max.
- Channels are fully independent. Simultaneous events on different channels all produce their pulses in the same cycle.
- No pulse is ever longer than 1 cycle.
- press_pulse and release_pulse are mutually exclusive per channel.
- rst asserted mid-count or mid-hold aborts immediately with no pulses.

Decomposition:
Package key_pkg:
- enum key_state_t {REL, HELD, LONG};
- function ms_to_cycles(freq, ms);
- function cnt_width(n).

Sub-module key_channel:
- one channel: synchroniser, debounce counter, FSM.
- Top instantiates N_KEYS copies in a generate loop and only concatenates outputs.

Test Plan:
Simulation parameters for all tests: CLK_FREQ_HZ=1000, DEBOUNCE_MS=4, LONG_MS=20, REPEAT_MS=5, i.e. DEB_CNT=4, LONG_CNT=20, REP_CNT=5.

1. Clean press: key_in[0] 0→1 sampled at edge 1 → key_level[0]=1 and press_pulse[0]=1 at edge 6, pulse low at edge 7; other channels stay 0.
2. Bounce: key_in[1] toggles 1,0,1,0 on successive cycles, then holds 1 → no pulses during bouncing; press_pulse[1] exactly once, 6 edges after the final stable transition.
3. Long press and repeat: hold key 2 for 40 cycles after acceptance → long_pulse at 20 cycles after press_pulse, repeat_pulse at +5, +10, +15, +20; release gives exactly one release_pulse and no further repeats.
4. Short press: press accepted, release accepted after 10 cycles → press_pulse, release_pulse, no long_pulse.
5. Simultaneous events and active-low: all 4 keys pressed on the same edge → 4 press_pulse bits high in the same cycle. Rerun with ACTIVE_LOW=1, pins idle high, driven low → identical responses.
6. Reset mid-operation: key held, rst=1 for 1 cycle during the LONG state → all outputs 0 at the next edge. Key still held → new press_pulse at edge DEB_CNT+2 after rst deasserts; no spurious release_pulse.
